// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } if_state_t;

endpackage

// File: rtl/if_stage_pc_unit.sv
// Program counter register with hold / +4 / redirect next-PC selection.
module pc_unit
   import if_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               load,
   input  logic [INSTR_W-1:0] load_pc,
   output logic [INSTR_W-1:0] pc
);

   logic [INSTR_W-1:0] pc_n;

   // Redirect wins over the sequential increment.
   always_comb begin
      pc_n = pc;
      if (load) begin
         pc_n = load_pc;
      end else if (inc) begin
         pc_n = pc + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_n;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: fetch FSM, squash tracking and decode-facing registers.
// Optional macro IF_MISALIGN_CHECK_EN halts the stage on a misaligned redirect.
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic [INSTR_W-1:0] instruction,
   output logic               inst_valid,
   output logic [31:0]        pc_out,
   output logic [31:0]        pc_plus4,
   output logic               misalign_err,
   output logic [1:0]         dbg_state
);

   // Handshake: imem_req is a one-cycle strobe with no grant; each request
   // gets exactly one imem_rvalid pulse some cycles later. Decode takes the
   // held instruction in any HOLD cycle with stall low.

   if_state_t   state, state_n;
   logic        squash, squash_n;
   logic        armed;
   logic        pc_inc, pc_load, capture, clear_valid;
   logic        misaligned, halt_set;
   logic [31:0] pc;

   pc_unit #(.RESET_PC(RESET_PC)) u_pc (
      .clk     (clk),
      .reset   (reset),
      .inc     (pc_inc),
      .load    (pc_load),
      .load_pc (redirect_pc & 32'hFFFF_FFFC),
      .pc      (pc)
   );

   // armed keeps imem_req low until the first edge after reset release,
   // so the strobe stays purely register-decoded.
   assign imem_req  = armed && (state == S_REQ);
   assign imem_addr = pc;
   assign pc_plus4  = pc_out + 32'd4;
   assign dbg_state = state;
   assign halt_set  = misaligned && (state != S_HALT);

`ifdef IF_MISALIGN_CHECK_EN
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_err <= 1'b0;
      end else if (halt_set) begin
         misalign_err <= 1'b1;
      end
   end
`else
   assign misaligned   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      squash_n    = squash;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      capture     = 1'b0;
      clear_valid = 1'b0;
      case (state)
         S_REQ: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               if (armed) begin
                  state_n  = S_WAIT;
                  squash_n = 1'b1;
               end
            end else if (armed) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               if (imem_rvalid) begin
                  state_n  = S_REQ;
                  squash_n = 1'b0;
               end else begin
                  squash_n = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (squash) begin
                  squash_n = 1'b0;
                  state_n  = S_REQ;
               end else begin
                  capture = 1'b1;
                  state_n = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_load     = 1'b1;
               clear_valid = 1'b1;
               state_n     = S_REQ;
            end else if (!stall) begin
               pc_inc      = 1'b1;
               clear_valid = 1'b1;
               state_n     = S_REQ;
            end
         end
         S_HALT: begin
            state_n = S_HALT;
         end
      endcase
      if (halt_set) begin
         state_n     = S_HALT;
         squash_n    = 1'b0;
         pc_inc      = 1'b0;
         pc_load     = 1'b0;
         capture     = 1'b0;
         clear_valid = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_REQ;
         squash <= 1'b0;
         armed  <= 1'b0;
      end else begin
         state  <= state_n;
         squash <= squash_n;
         armed  <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= NOP_INSTR;
         inst_valid  <= 1'b0;
         pc_out      <= RESET_PC;
      end else if (capture) begin
         instruction <= imem_rdata;
         inst_valid  <= 1'b1;
         pc_out      <= pc;
      end else if (clear_valid) begin
         inst_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized fetch/redirect mix.
module tb_if_stage;
   import if_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_rvalid, stall, redirect_valid;
   logic        inst_valid, misalign_err;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out, pc_plus4;
   logic [1:0]  dbg_state;

   logic        w_req, w_rvalid, w_inst_valid, w_misalign_err;
   logic [31:0] w_addr, w_rdata, w_instruction, w_pc_out, w_pc_plus4;
   logic [1:0]  w_dbg_state;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instruction(instruction), .inst_valid(inst_valid), .pc_out(pc_out),
      .pc_plus4(pc_plus4), .misalign_err(misalign_err), .dbg_state(dbg_state)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instruction(w_instruction), .inst_valid(w_inst_valid), .pc_out(w_pc_out),
      .pc_plus4(w_pc_plus4), .misalign_err(w_misalign_err), .dbg_state(w_dbg_state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_req(input string name, input logic [31:0] addr);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s: req=%0b addr=%h valid=%0b, expected req=1 addr=%h valid=0",
                  name, imem_req, imem_addr, inst_valid, addr);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s: req=%0b valid=%0b, expected req=0 valid=0", name, imem_req, inst_valid);
      end
   endtask

   // Leaves the bench in cycle 0 (first cycle after the first edge following release).
   task automatic apply_reset;
      reset = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      w_rvalid = 1'b0; w_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || instruction !== 32'h0000_0013 ||
          pc_out !== 32'h0 || misalign_err !== 1'b0 || pc_plus4 !== 32'h4) begin
         failures++;
         $display("FAIL reset_vals: req=%0b valid=%0b instr=%h pc_out=%h err=%0b p4=%h, expected 0 0 00000013 0 0 4",
                  imem_req, inst_valid, instruction, pc_out, misalign_err, pc_plus4);
      end
      checks++;
      if (w_req !== 1'b0 || w_pc_out !== 32'hFFFF_FFFC || w_inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_vals_w: req=%0b pc_out=%h valid=%0b, expected 0 fffffffc 0",
                  w_req, w_pc_out, w_inst_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      exp_pc = 32'h0;
      exp_q.delete();
   endtask

   // Starts in a REQ cycle; ends in the next REQ cycle (or REQ after redirect).
   task automatic do_fetch(input int lat, input logic [31:0] data, input int nstall,
                           input bit junk, input bit redir, input logic [31:0] target);
      logic [31:0] held;
      check_req("fetch_req", exp_pc);
      if (junk) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end
      for (int i = 0; i < lat; i++) begin
         tick();
         imem_rvalid = 1'b0;
         stall = 1'($urandom_range(0, 1));
         check_idle("fetch_wait");
      end
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      exp_q.push_back(data);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      held = exp_q.pop_front();
      checks++;
      if (inst_valid !== 1'b1 || instruction !== held || pc_out !== exp_pc ||
          pc_plus4 !== exp_pc + 32'd4 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL fetch_data: valid=%0b instr=%h pc_out=%h p4=%h req=%0b, expected 1 %h %h %h 0",
                  inst_valid, instruction, pc_out, pc_plus4, imem_req, held, exp_pc, exp_pc + 32'd4);
      end
      for (int i = 0; i < nstall; i++) begin
         stall = 1'b1;
         imem_rvalid = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (inst_valid !== 1'b1 || instruction !== held || pc_out !== exp_pc || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: valid=%0b instr=%h pc_out=%h req=%0b, expected 1 %h %h 0",
                     inst_valid, instruction, pc_out, imem_req, held, exp_pc);
         end
      end
      imem_rvalid = 1'b0;
      if (redir) begin
         stall = 1'b1;
         redirect_valid = 1'b1;
         redirect_pc = target;
         tick();
         redirect_valid = 1'b0;
         stall = 1'b0;
         exp_pc = target & 32'hFFFF_FFFC;
         check_req("hold_redirect", exp_pc);
      end else begin
         stall = 1'b0;
         tick();
         exp_pc = exp_pc + 32'd4;
         check_req("next_req", exp_pc);
      end
   endtask

   task automatic redirect_wait(input logic [31:0] target, input int gap);
      check_req("rw_req", exp_pc);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = target;
      tick();
      redirect_valid = 1'b0;
      check_idle("rw_squash");
      for (int i = 0; i < gap; i++) begin
         tick();
         check_idle("rw_gap");
      end
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      exp_pc = target & 32'hFFFF_FFFC;
      check_req("rw_new_req", exp_pc);
   endtask

   task automatic redirect_same(input logic [31:0] target, input int lat);
      check_req("rs_req", exp_pc);
      for (int i = 0; i < lat; i++) begin
         tick();
         check_idle("rs_wait");
      end
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
      redirect_valid = 1'b1;
      redirect_pc = target;
      tick();
      imem_rvalid = 1'b0;
      redirect_valid = 1'b0;
      exp_pc = target & 32'hFFFF_FFFC;
      check_req("rs_new_req", exp_pc);
   endtask

   task automatic redirect_req(input logic [31:0] target, input int gap);
      check_req("rq_req", exp_pc);
      redirect_valid = 1'b1;
      redirect_pc = target;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         check_idle("rq_wait");
         tick();
      end
      check_idle("rq_wait");
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
      tick();
      imem_rvalid = 1'b0;
      exp_pc = target & 32'hFFFF_FFFC;
      check_req("rq_new_req", exp_pc);
   endtask

   task automatic test_reset;
      apply_reset();
   endtask

   task automatic test_basic;
      apply_reset();
      do_fetch(1, 32'h0050_0093, 0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_addr !== 32'h4) begin
         failures++;
         $display("FAIL basic_addr4: addr=%h expected 00000004", imem_addr);
      end
   endtask

   task automatic test_stall;
      apply_reset();
      do_fetch(1, $urandom, 3, 1'b0, 1'b0, 32'h0);
      do_fetch(2, $urandom, 0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_redirect;
      apply_reset();
      redirect_wait(32'h100, 2);
      do_fetch(1, $urandom, 0, 1'b0, 1'b0, 32'h0);
      redirect_same(32'h200, 2);
      do_fetch(2, $urandom, 1, 1'b0, 1'b0, 32'h0);
      redirect_req(32'h300, 1);
      do_fetch(1, $urandom, 2, 1'b0, 1'b1, 32'h400);
      do_fetch(3, $urandom, 0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset_mid_fetch;
      check_req("mid_req", exp_pc);
      tick();
      apply_reset();
      do_fetch(2, $urandom, 0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_wrap;
      logic [31:0] wd;
      apply_reset();
      wd = $urandom;
      checks++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_first: req=%0b addr=%h expected 1 fffffffc", w_req, w_addr);
      end
      tick();
      w_rvalid = 1'b1;
      w_rdata = wd;
      tick();
      w_rvalid = 1'b0;
      checks++;
      if (w_inst_valid !== 1'b1 || w_instruction !== wd || w_pc_out !== 32'hFFFF_FFFC ||
          w_pc_plus4 !== 32'h0 || w_misalign_err !== 1'b0) begin
         failures++;
         $display("FAIL wrap_data: valid=%0b instr=%h pc_out=%h p4=%h, expected 1 %h fffffffc 00000000",
                  w_inst_valid, w_instruction, w_pc_out, w_pc_plus4, wd);
      end
      tick();
      checks++;
      if (w_req !== 1'b1 || w_addr !== 32'h0 || w_inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_second: req=%0b addr=%h valid=%0b expected 1 00000000 0",
                  w_req, w_addr, w_inst_valid);
      end
   endtask

   task automatic test_misalign;
      apply_reset();
      do_fetch(1, $urandom, 0, 1'b0, 1'b0, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
      check_req("mis_req", exp_pc);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b1) begin
            failures++;
            $display("FAIL misalign_halt: req=%0b valid=%0b err=%0b expected 0 0 1",
                     imem_req, inst_valid, misalign_err);
         end
         imem_rvalid = 1'($urandom_range(0, 1));
         stall = 1'($urandom_range(0, 1));
         redirect_valid = 1'($urandom_range(0, 1));
         redirect_pc = 32'h500;
         tick();
      end
      apply_reset();
      do_fetch(1, $urandom, 0, 1'b0, 1'b0, 32'h0);
`else
      redirect_wait(32'h102, 1);
      checks++;
      if (misalign_err !== 1'b0 || imem_addr !== 32'h100) begin
         failures++;
         $display("FAIL misalign_off: err=%0b addr=%h expected 0 00000100", misalign_err, imem_addr);
      end
      do_fetch(1, $urandom, 0, 1'b0, 1'b0, 32'h0);
`endif
   endtask

   task automatic test_random;
      logic [31:0] t;
      for (int n = 0; n < 40; n++) begin
         t = $urandom;
`ifdef IF_MISALIGN_CHECK_EN
         t[1:0] = 2'b00;
`endif
         case ($urandom_range(0, 5))
            0, 1: do_fetch($urandom_range(1, 4), $urandom, $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), 1'b0, 32'h0);
            2: redirect_wait(t, $urandom_range(0, 3));
            3: redirect_same(t, $urandom_range(1, 3));
            4: redirect_req(t, $urandom_range(0, 3));
            default: do_fetch($urandom_range(1, 4), $urandom, $urandom_range(0, 2),
                              1'b0, 1'b1, t);
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_reset_mid_fetch();
      test_wrap();
      test_misalign();
      apply_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
